keypad_hex_scanner: RTL

//   Input-side counterpart of the SSD digit path: scans a 4x4 hex keypad matrix
//   and turns a debounced key press into a 4-bit hex digit plus a one-cycle strobe.
//   The output digit feeds the SSD digit mapper directly.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_hex_scanner_if.sv | 26 ++
 rtl/keypad_key_mapper.sv | 12 +
 rtl/keypad_hex_scanner.sv | 125 ++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner: FSM states,
// matrix geometry and the {row,col} -> hex digit table.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Indexed by {row,col}; row 3 is the "E 0 F D" bottom row of the pad.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Index of the lowest active-low column; only meaningful when some bit is low.
  function automatic logic [1:0] lowest_low(input logic [COLS-1:0] v_n);
    lowest_low = 2'd0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!v_n[i]) lowest_low = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_hex_scanner_if.sv
// Keypad pin and digit-output bundle between the scanner and its neighbours.
interface keypad_hex_scanner_if;
  import keypad_pkg::*;

  logic [ROWS-1:0] rows_n;
  logic [COLS-1:0] cols_n;
  logic [3:0]      digit;
  logic            digit_valid;
  logic            key_held;

  modport master (
    output rows_n,
    output digit,
    output digit_valid,
    output key_held,
    input  cols_n
  );

  modport slave (
    input  rows_n,
    input  digit,
    input  digit_valid,
    input  key_held,
    output cols_n
  );
endinterface

// File: rtl/keypad_key_mapper.sv
// Combinational lookup of the hex digit printed on key {row,col}.
module keypad_key_mapper
  import keypad_pkg::*;
(
  input  logic [1:0] row_i,
  input  logic [1:0] col_i,
  output logic [3:0] digit_o
);

  assign digit_o = KEY_MAP[{row_i, col_i}];

endmodule

// File: rtl/keypad_hex_scanner.sv
// Row-scanning 4x4 keypad reader: synchronises the columns, debounces press
// and release of one latched key and emits a one-cycle strobe per accepted press.
module keypad_hex_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  keypad_hex_scanner_if.master kp
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [COLS-1:0] sync1_q, cs_n_q;
  state_e          state_q, state_d;
  logic [1:0]      row_q, row_d;
  logic [1:0]      col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]      digit_q, digit_d;
  logic            dv_q, dv_d;
  logic            held_q, held_d;
  logic [3:0]      map_digit;
  logic            col_low;

  keypad_key_mapper u_mapper (
    .row_i   (row_q),
    .col_i   (col_q),
    .digit_o (map_digit)
  );

  assign col_low = !cs_n_q[col_q];

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    dv_d    = 1'b0;
    case (state_q)
      SCAN: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (cs_n_q != {COLS{1'b1}}) begin
            col_d   = lowest_low(cs_n_q);
            state_d = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!col_low) begin
          cnt_d   = '0;
          state_d = SCAN;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          digit_d = map_digit;
          dv_d    = 1'b1;
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!col_low) begin
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // A bounce back to low returns to PRESSED silently; the press was already reported.
        if (col_low) begin
          cnt_d   = '0;
          state_d = PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d   = '0;
          row_d   = row_q + 2'd1;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
    held_d = (state_d == PRESSED) || (state_d == RELEASE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= {COLS{1'b1}};
      cs_n_q  <= {COLS{1'b1}};
      state_q <= SCAN;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      cnt_q   <= '0;
      digit_q <= 4'h0;
      dv_q    <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= kp.cols_n;
      cs_n_q  <= sync1_q;
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      dv_q    <= dv_d;
      held_q  <= held_d;
    end
  end

  assign kp.rows_n      = ~(4'b0001 << row_q);
  assign kp.digit       = digit_q;
  assign kp.digit_valid = dv_q;
  assign kp.key_held    = held_q;

endmodule
